// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, default bit timing
// and the receiver state encoding.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 5208;
    localparam int DATA_BITS            = 8;
    localparam logic STOP_LEVEL         = 1'b1;

    localparam int CNT_W = 13;
    localparam int IDX_W = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver output bundle: byte, valid/error pulses, busy and
// sample-point debug tick. master = receiver, slave = consumer.
interface uart_rx_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
    logic       o_sample_tick;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output busy,
        output o_sample_tick
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input frame_err,
        input busy,
        input o_sample_tick
    );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for an asynchronous input.
// Ports: clk, rst_n, d_i (async in), q_o (synchronized out).
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling, framing check.
// Ports: clk, rst_n, rx_serial (async line), rx_if (output bundle).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx_serial,
    uart_rx_if.master rx_if
);

    localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic rx_sync;

    rx_state_e             state_q;
    logic [CNT_W-1:0]      clk_count_q;
    logic [IDX_W-1:0]      bit_index_q;
    logic [DATA_BITS-1:0]  shift_q;
    logic [DATA_BITS-1:0]  rx_data_q;
    logic                  rx_valid_q;
    logic                  frame_err_q;
    logic                  busy_q;
    logic                  tick_q;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx_serial),
        .q_o   (rx_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            clk_count_q <= '0;
            bit_index_q <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            tick_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q      <= 1'b0;
                    clk_count_q <= '0;
                    bit_index_q <= '0;
                    if (!rx_sync) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (clk_count_q < HALF_CNT) begin
                        clk_count_q <= clk_count_q + 1'b1;
                    end else begin
                        tick_q      <= 1'b1;
                        clk_count_q <= '0;
                        if (!rx_sync) begin
                            state_q <= DATA;
                        end else begin
                            // Line back high at mid-start: glitch.
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (clk_count_q < FULL_CNT) begin
                        clk_count_q <= clk_count_q + 1'b1;
                    end else begin
                        tick_q               <= 1'b1;
                        clk_count_q          <= '0;
                        shift_q[bit_index_q] <= rx_sync;
                        if (bit_index_q == LAST_IDX) begin
                            state_q     <= STOP;
                            bit_index_q <= '0;
                        end else begin
                            bit_index_q <= bit_index_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (clk_count_q < FULL_CNT) begin
                        clk_count_q <= clk_count_q + 1'b1;
                    end else begin
                        tick_q      <= 1'b1;
                        clk_count_q <= '0;
                        if (rx_sync == STOP_LEVEL) begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    // Hold off a break so it cannot retrigger START.
                    if (rx_sync) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    clk_count_q <= '0;
                    bit_index_q <= '0;
                end
            endcase
        end
    end

    assign rx_if.rx_data       = rx_data_q;
    assign rx_if.rx_valid      = rx_valid_q;
    assign rx_if.frame_err     = frame_err_q;
    assign rx_if.busy          = busy_q;
    assign rx_if.o_sample_tick = tick_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

    localparam int CPB = 16;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    logic rx_serial;

    uart_rx_if rif ();

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_serial (rx_serial),
        .rx_if     (rif)
    );

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    exp_t sb_q[$];
    int   tick_times[$];
    int   low_runs[$];
    bit   tick_en = 0;
    bit   track   = 0;
    int   low_run = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: pop expected entry on every valid/error pulse.
    always @(negedge clk) begin
        if (rst_n && (rif.rx_valid || rif.frame_err)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_evt",
                    {30'd0, rif.rx_valid, rif.frame_err}, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("evt_valid", rif.rx_valid, int'(!e.err));
                chk("evt_ferr", rif.frame_err, int'(e.err));
                chk("evt_data", rif.rx_data, e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (tick_en && rif.o_sample_tick) tick_times.push_back(cyc);
    end

    always @(negedge clk) begin
        if (!rif.busy) begin
            low_run++;
        end else if (low_run > 0) begin
            if (track) low_runs.push_back(low_run);
            low_run = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic cw(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mode 0: 16 clk bits, 1: 17 clk, 2: alternating 16/15
    task automatic send_frame(input logic [7:0] d,
                              input logic stop,
                              input int mode);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int j = 0; j < 10; j++) begin
            rx_serial = bits[j];
            if (mode == 1) cw(17);
            else if (mode == 2 && j[0]) cw(15);
            else cw(16);
        end
    endtask

    task automatic push(input logic err, input logic [7:0] d);
        exp_t e;
        e.err  = err;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) cw(1);
        chk(nm, sb_q.size(), 0);
    endtask

    initial begin
        int hi;
        rst_n     = 0;
        rx_serial = 1;
        cw(3);
        chk("rst_data", rif.rx_data, 0);
        chk("rst_valid", rif.rx_valid, 0);
        chk("rst_ferr", rif.frame_err, 0);
        chk("rst_busy", rif.busy, 0);
        chk("rst_tick", rif.o_sample_tick, 0);
        rst_n = 1;
        cw(5);

        // single byte + tick spacing
        tick_times.delete();
        tick_en = 1;
        push(0, 8'hA5);
        send_frame(8'hA5, 1, 0);
        cw(4);
        drain("drain_a5");
        tick_en = 0;
        chk("tick_count", tick_times.size(), 10);
        if (tick_times.size() == 10)
            for (int i = 1; i < 10; i++)
                chk("tick_space", tick_times[i] - tick_times[i-1], CPB);

        // back-to-back
        low_runs.delete();
        track = 1;
        push(0, 8'h00);
        push(0, 8'hFF);
        push(0, 8'h3C);
        send_frame(8'h00, 1, 0);
        send_frame(8'hFF, 1, 0);
        send_frame(8'h3C, 1, 0);
        cw(20);
        drain("drain_b2b");
        track = 0;
        chk("b2b_runs", low_runs.size(), 3);
        if (low_runs.size() == 3) begin
            chk("b2b_gap1", low_runs[1], 8);
            chk("b2b_gap2", low_runs[2], 8);
        end

        // glitch rejection
        rx_serial = 0;
        cw(3);
        rx_serial = 1;
        hi = 0;
        repeat (30) begin
            @(negedge clk);
            if (rif.busy) hi++;
        end
        cw(1);
        chk("glitch_busy", hi, 8);
        chk("glitch_sb", sb_q.size(), 0);

        // framing error then break
        push(1, 8'h3C);
        send_frame(8'h55, 0, 0);
        cw(50);
        chk("ferr_busy_hold", rif.busy, 1);
        chk("ferr_data_keep", rif.rx_data, 8'h3C);
        rx_serial = 1;
        cw(2);
        chk("ferr_busy_sync", rif.busy, 1);
        cw(3);
        chk("ferr_busy_rel", rif.busy, 0);
        drain("drain_ferr");
        push(0, 8'h81);
        send_frame(8'h81, 1, 0);
        cw(4);
        drain("drain_81");

        // reset during DATA bit 4 of 0xC3
        begin
            logic [7:0] d;
            d = 8'hC3;
            rx_serial = 0;
            cw(16);
            for (int j = 0; j < 4; j++) begin
                rx_serial = d[j];
                cw(16);
            end
            rx_serial = d[4];
            cw(8);
        end
        chk("pre_rst_busy", rif.busy, 1);
        rst_n = 0;
        #1;
        chk("mid_rst_busy", rif.busy, 0);
        chk("mid_rst_data", rif.rx_data, 0);
        chk("mid_rst_valid", rif.rx_valid, 0);
        chk("mid_rst_ferr", rif.frame_err, 0);
        chk("mid_rst_tick", rif.o_sample_tick, 0);
        rx_serial = 1;
        cw(3);
        rst_n = 1;
        cw(20);
        push(0, 8'h7E);
        send_frame(8'h7E, 1, 0);
        cw(4);
        drain("drain_7e");

        // baud tolerance
        push(0, 8'h96);
        send_frame(8'h96, 1, 1);
        cw(20);
        drain("drain_slow");
        push(0, 8'h96);
        send_frame(8'h96, 1, 2);
        cw(20);
        drain("drain_fast");

        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
